// File: rtl/stack_pkg.sv
// Shared encodings for the LSU stack sequencer and the LSU top that wires it to sp.
package stack_pkg;
  typedef enum logic [2:0] {IDLE, WR, INC, DEC, RD} state_t;

  localparam logic SP_INC = 1'b1;
  localparam logic SP_DEC = 1'b0;
endpackage

// File: rtl/stack_ctrl.sv
// Push/pop sequencer: steps the sibling sp register and issues one memory word
// transaction per operation, with sticky overflow/underflow flags.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int          AW          = 16,
  parameter int          DW          = 16,
  parameter logic [15:0] STACK_BASE  = 16'h0100,
  parameter logic [15:0] STACK_LIMIT = 16'h0200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic          op_push,
  input  logic [DW-1:0] op_wdata,
  output logic          op_ready,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  input  logic [AW-1:0] sp_q,
  output logic          sp_d,
  output logic          sp_en,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err_overflow,
  output logic          err_underflow,
  input  logic          err_clr,
  output logic [AW-1:0] depth
);

  state_t state;
  logic   full;
  logic   empty;

  assign full     = (sp_q == AW'(STACK_LIMIT));
  assign empty    = (sp_q == AW'(STACK_BASE));
  assign op_ready = (state == IDLE);
  assign depth    = sp_q - AW'(STACK_BASE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pop_valid     <= 1'b0;
      pop_data      <= '0;
      sp_d          <= SP_DEC;
      sp_en         <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      sp_en     <= 1'b0;
      pop_valid <= 1'b0;
      // Clear first so that an error raised in the same cycle wins.
      if (err_clr) begin
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (op_push) begin
              if (full) begin
                err_overflow <= 1'b1;
              end else begin
                state     <= WR;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= sp_q;
                mem_wdata <= op_wdata;
              end
            end else begin
              if (empty) begin
                err_underflow <= 1'b1;
              end else begin
                state <= DEC;
                sp_en <= 1'b1;
                sp_d  <= SP_DEC;
              end
            end
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= INC;
            sp_en   <= 1'b1;
            sp_d    <= SP_INC;
          end
        end
        INC: state <= IDLE;
        DEC: begin
          // sp steps on this same edge, so the address it will hold is sp_q - 1.
          state    <= RD;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= sp_q - AW'(1);
        end
        RD: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            pop_data  <= mem_rdata;
            pop_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: models sp and a word memory with programmable ack delay.
module tb_stack_ctrl;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam logic [15:0] LIMIT = 16'h0104;
  localparam int          CAP   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sp_rst = 1'b0;
  logic        op_valid = 1'b0, op_push = 1'b0, err_clr = 1'b0;
  logic [15:0] op_wdata = '0;
  logic        op_ready, pop_valid, sp_d, sp_en, mem_req, mem_we, mem_ack;
  logic [15:0] pop_data, mem_addr, mem_wdata, mem_rdata, depth;
  logic        err_overflow, err_underflow;
  logic [15:0] sp_q;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_dly = 0;
  int wcnt    = 0;

  stack_ctrl #(.AW(16), .DW(16), .STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_push(op_push), .op_wdata(op_wdata),
    .op_ready(op_ready), .pop_valid(pop_valid), .pop_data(pop_data), .sp_q(sp_q),
    .sp_d(sp_d), .sp_en(sp_en), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr),
    .depth(depth)
  );

  always #5 clk = ~clk;

  // sp register model
  always_ff @(posedge clk or negedge sp_rst) begin
    if (!sp_rst) sp_q <= BASE;
    else if (sp_en) sp_q <= sp_d ? sp_q + 16'd1 : sp_q - 16'd1;
  end

  // memory model
  logic [15:0] mem [0:255];
  assign mem_ack   = mem_req && (wcnt >= ack_dly);
  assign mem_rdata = mem[mem_addr[7:0]];
  always_ff @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  // event monitor
  int c_inc = 0, c_dec = 0, c_wr = 0, c_rd = 0, c_pv = 0;
  logic [15:0] l_waddr = '0, l_wdata = '0, l_raddr = '0, l_pd = '0;
  always @(negedge clk) begin
    if (sp_en && sp_d) c_inc++;
    if (sp_en && !sp_d) c_dec++;
    if (mem_req && mem_ack && mem_we) begin c_wr++; l_waddr = mem_addr; l_wdata = mem_wdata; end
    if (mem_req && mem_ack && !mem_we) begin c_rd++; l_raddr = mem_addr; end
    if (pop_valid) begin c_pv++; l_pd = pop_data; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " op_ready"},  32'(op_ready), 32'd1);
    chk({tag, " pop_valid"}, 32'(pop_valid), 32'd0);
    chk({tag, " pop_data"},  32'(pop_data), 32'd0);
    chk({tag, " sp_en"},     32'(sp_en), 32'd0);
    chk({tag, " sp_d"},      32'(sp_d), 32'd0);
    chk({tag, " mem_req"},   32'(mem_req), 32'd0);
    chk({tag, " mem_we"},    32'(mem_we), 32'd0);
    chk({tag, " mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, " errors"},    32'({err_overflow, err_underflow}), 32'd0);
  endtask

  // Issue one op; lat = cycles from accept until op_ready is seen again.
  task automatic do_op(input bit push, input logic [15:0] data, input bit clr, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!op_ready && n < 50) begin @(negedge clk); n++; end
    op_valid = 1'b1; op_push = push; op_wdata = data; err_clr = clr;
    @(posedge clk);
    #1;
    op_valid = 1'b0; err_clr = 1'b0; op_wdata = 16'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!op_ready && lat < 50);
    #1;
  endtask

  typedef struct {
    bit          push;
    bit          clr;
    logic [15:0] data;
    int          lat;
    bit          pv;
    logic [15:0] pd;
    logic [15:0] dep;
    bit          ov;
    bit          un;
  } vec_t;
  vec_t tbl [13];

  // reference model state
  logic [15:0] stk [$];
  bit m_ov = 1'b0, m_un = 1'b0;

  task automatic run_op(input bit push, input logic [15:0] data, input bit clr);
    int lat, b_inc, b_dec, b_wr, b_rd, b_pv, sz;
    bit ok;
    logic [15:0] exp_pd;
    sz = stk.size();
    ok = push ? (sz < CAP) : (sz > 0);
    if (clr) begin m_ov = 1'b0; m_un = 1'b0; end
    if (!ok && push) m_ov = 1'b1;
    if (!ok && !push) m_un = 1'b1;
    exp_pd = '0;
    if (ok && push) stk.push_back(data);
    if (ok && !push) exp_pd = stk.pop_back();
    b_inc = c_inc; b_dec = c_dec; b_wr = c_wr; b_rd = c_rd; b_pv = c_pv;
    do_op(push, data, clr, lat);
    chk("rnd latency", 32'(lat), ok ? 32'(3 + ack_dly) : 32'd1);
    chk("rnd inc",     32'(c_inc - b_inc), 32'(ok && push));
    chk("rnd dec",     32'(c_dec - b_dec), 32'(ok && !push));
    chk("rnd writes",  32'(c_wr - b_wr), 32'(ok && push));
    chk("rnd reads",   32'(c_rd - b_rd), 32'(ok && !push));
    chk("rnd popvld",  32'(c_pv - b_pv), 32'(ok && !push));
    chk("rnd depth",   32'(depth), 32'(stk.size()));
    chk("rnd sp_q",    32'(sp_q), 32'(BASE) + 32'(stk.size()));
    chk("rnd errs",    32'({err_overflow, err_underflow}), 32'({m_ov, m_un}));
    if (ok && push) begin
      chk("rnd waddr", 32'(l_waddr), 32'(BASE) + 32'(sz));
      chk("rnd wdata", 32'(l_wdata), 32'(data));
    end
    if (ok && !push) begin
      chk("rnd raddr", 32'(l_raddr), 32'(BASE) + 32'(sz) - 32'd1);
      chk("rnd pdata", 32'(l_pd), 32'(exp_pd));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int lat, b_inc, b_dec, b_wr, b_rd, b_pv;
    logic [15:0] sp_keep;

    // Asynchronous reset asserted mid-cycle
    #3 rst = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clk); sp_rst = 1'b1;
    @(negedge clk); rst = 1'b1;

    tbl[0]  = '{1'b1, 1'b0, 16'hBEEF, 3, 1'b0, 16'h0000, 16'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 3, 1'b1, 16'hBEEF, 16'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 16'h1111, 3, 1'b0, 16'h0000, 16'd1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 16'h2222, 3, 1'b0, 16'h0000, 16'd2, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'h3333, 3, 1'b0, 16'h0000, 16'd3, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 16'h4444, 3, 1'b0, 16'h0000, 16'd4, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 16'h5555, 1, 1'b0, 16'h0000, 16'd4, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 3, 1'b1, 16'h4444, 16'd3, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 16'h0000, 3, 1'b1, 16'h3333, 16'd2, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 3, 1'b1, 16'h2222, 16'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 3, 1'b1, 16'h1111, 16'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 16'h0000, 1, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b1};

    ack_dly = 0;
    for (int i = 0; i < 13; i++) begin
      bit act;
      act = (tbl[i].lat > 1);
      b_inc = c_inc; b_dec = c_dec; b_wr = c_wr; b_rd = c_rd; b_pv = c_pv;
      do_op(tbl[i].push, tbl[i].data, tbl[i].clr, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d inc", i),     32'(c_inc - b_inc), 32'(act && tbl[i].push));
      chk($sformatf("vec%0d dec", i),     32'(c_dec - b_dec), 32'(act && !tbl[i].push));
      chk($sformatf("vec%0d writes", i),  32'(c_wr - b_wr), 32'(act && tbl[i].push));
      chk($sformatf("vec%0d reads", i),   32'(c_rd - b_rd), 32'(act && !tbl[i].push));
      chk($sformatf("vec%0d popvld", i),  32'(c_pv - b_pv), 32'(tbl[i].pv));
      if (tbl[i].pv) chk($sformatf("vec%0d pdata", i), 32'(l_pd), 32'(tbl[i].pd));
      chk($sformatf("vec%0d depth", i),   32'(depth), 32'(tbl[i].dep));
      chk($sformatf("vec%0d sp_q", i),    32'(sp_q), 32'(BASE) + 32'(tbl[i].dep));
      chk($sformatf("vec%0d ovf", i),     32'(err_overflow), 32'(tbl[i].ov));
      chk($sformatf("vec%0d unf", i),     32'(err_underflow), 32'(tbl[i].un));
      if (i == 0) begin
        chk("vec0 waddr", 32'(l_waddr), 32'h0100);
        chk("vec0 wdata", 32'(l_wdata), 32'hBEEF);
      end
      if (i == 1) chk("vec1 raddr", 32'(l_raddr), 32'h0100);
    end

    // Standalone err_clr pulse
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clr underflow", 32'(err_underflow), 32'd0);
    chk("err_clr overflow",  32'(err_overflow), 32'd0);

    // Randomized ops against the queue model; stack is empty and flags are clear here
    stk.delete(); m_ov = 1'b0; m_un = 1'b0;
    for (int i = 0; i < 150; i++) begin
      ack_dly = $urandom_range(0, 3);
      run_op($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 19) == 0);
    end

    // Reset in the second WR cycle of a slow push
    if (stk.size() == CAP) run_op(1'b0, 16'h0, 1'b0);
    ack_dly = 3;
    sp_keep = sp_q;
    b_inc = c_inc; b_dec = c_dec; b_wr = c_wr;
    @(negedge clk);
    op_valid = 1'b1; op_push = 1'b1; op_wdata = 16'hCAFE;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst req before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst no sp_en", 32'(c_inc + c_dec), 32'(b_inc + b_dec));
    chk("midrst no write", 32'(c_wr), 32'(b_wr));
    chk("midrst sp_q",     32'(sp_q), 32'(sp_keep));
    chk("midrst mem_req",  32'(mem_req), 32'd0);
    chk("midrst op_ready", 32'(op_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer for the LSU stack: accepts push/pop operations from the core, drives the sibling `sp` stack-pointer register through its `d`/`en` inputs, and issues the matching word transaction on the LSU memory port. It bounds-checks the stack against a fixed window and flags overflow and underflow. It sits in the LSU between the core's stack-op interface, the `sp` instance and the memory port.

## Interface
- `AW`, 16, address width; equals `sp` output width.
- `DW`, 16, data word width.
- `STACK_BASE`, 16'h0100, empty value of `sp_q`; the first push writes here.
- `STACK_LIMIT`, 16'h0200, full value of `sp_q` (exclusive top).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `op_valid` in 1: operation request; held stable until accepted.
- `op_push` in 1: 1 = push, 0 = pop.
- `op_wdata` in DW: push data.
- `op_ready` out 1: controller idle; accept when `op_valid && op_ready`.
- `pop_valid` out 1: one-cycle pulse, `pop_data` valid.
- `pop_data` out DW: popped word, registered.
- `sp_q` in AW: current stack pointer from `sp`.
- `sp_d` out 1: `sp` direction; 1 = increment, 0 = decrement.
- `sp_en` out 1: `sp` step enable; one-cycle pulse.
- `mem_req` out 1: memory request; held until `mem_ack`.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out AW: word address.
- `mem_wdata` out DW: write data.
- `mem_ack` in 1: completion; may arrive in the same cycle as `mem_req`.
- `mem_rdata` in DW: read data, valid with `mem_ack`.
- `err_overflow` out 1: sticky; push attempted while full.
- `err_underflow` out 1: sticky; pop attempted while empty.
- `err_clr` in 1: clears both sticky flags.
- `depth` out AW: `sp_q - STACK_BASE`, modulo 2^AW.

## Operation
- Empty-ascending stack: `sp_q` points at the next free word. Empty when `sp_q == STACK_BASE`; full when `sp_q == STACK_LIMIT`.
- States and transitions:
  - IDLE → WR on an accepted push that is not full.
  - IDLE → DEC on an accepted pop that is not empty.
  - WR → INC on `mem_ack`.
  - INC → IDLE.
  - DEC → RD.
  - RD → IDLE on `mem_ack`.
- WR drives `mem_req=1`, `mem_we=1`, `mem_addr=sp_q`, `mem_wdata` = latched `op_wdata`.
- INC drives `sp_en=1`, `sp_d=1`.
- DEC drives `sp_en=1`, `sp_d=0`. RD then uses the already-updated `sp_q` as `mem_addr`, with `mem_we=0`.
- On RD with `mem_ack`: `pop_data <= mem_rdata`, and `pop_valid` pulses the next cycle, which is also the cycle the state is IDLE again.
- `op_ready = (state == IDLE)`. `op_wdata` is latched on accept.
- Push while full: the op is accepted, `err_overflow` is set, and the controller stays in IDLE with no memory or `sp` activity.
- Pop while empty: the op is accepted, `err_underflow` is set, and there is no `pop_valid`.
- `err_clr` and a new error in the same cycle: set wins.
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req` is high. `sp_en` is never high outside INC/DEC.

## Timing
- Reset values: state IDLE, `op_ready=1`, `pop_valid=0`, `pop_data=0`, `sp_en=0`, `sp_d=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, both error flags 0.
- Push with zero-wait ack: accept at cycle 0, WR at cycle 1, INC at cycle 2, `op_ready` high at cycle 3.
- Pop with zero-wait ack: accept at cycle 0, DEC at cycle 1, RD at cycle 2, `pop_valid` and `op_ready` at cycle 3.
- Each cycle of delay on `mem_ack` adds one cycle of latency.
- Reset asserted mid-operation: all outputs return to reset values immediately (async). No `sp_en` pulse is issued afterwards, so a push reset in WR leaves `sp` unchanged. `sp` has its own reset.

## Structure
- `stack_pkg`: state encoding (IDLE, WR, INC, DEC, RD) and the `SP_INC=1`/`SP_DEC=0` direction constants, shared with the LSU top.
- No sub-module: `sp` is instantiated as a sibling in the LSU top and wired to `sp_d`, `sp_en` and `sp_q`.

## Test plan
All scenarios use defaults except `STACK_LIMIT=16'h0104`. The bench models `sp` and memory.
- Reset: assert `rst` low mid-cycle → all outputs at reset values asynchronously; `op_ready=1`.
- Push 16'hBEEF at `sp_q=0x0100`, ack with zero wait → one write to `0x0100` with data `0xBEEF`, one `sp_en` with `sp_d=1`, `sp_q=0x0101`, `op_ready` back 3 cycles after accept.
- Pop next, memory returns `0xBEEF` → `sp_en` with `sp_d=0`, read of `0x0100`, one-cycle `pop_valid` with `pop_data=0xBEEF`, `sp_q=0x0100`.
- Pop at empty → `err_underflow=1`, no `mem_req`, no `sp_en`, no `pop_valid`. Pulse `err_clr` → flag 0.
- Four pushes, then a fifth → `sp_q` ends at `0x0104` and `depth=4`. The fifth sets `err_overflow`, with no `mem_req` and no `sp_en`.
- Push with `mem_ack` delayed 3 cycles, `rst` asserted in the second WR cycle → `mem_req` drops immediately, `sp_en` is never pulsed, `sp_q` is unchanged.
